// File: rtl/bus_burst_reader_pkg.sv
// Shared types and helpers for the burst read master: FSM state encoding,
// default word width and the index/beat-count arithmetic.
package bus_burst_reader_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Next register index, wrapping from modulus-1 back to 0.
  function automatic int wrap_inc(input int idx, input int modulus);
    return (idx + 1 >= modulus) ? 0 : idx + 1;
  endfunction

  // Requested beats above the register count collapse to one full pass.
  function automatic int clamp_beats(input int req, input int max_beats);
    return (req > max_beats) ? max_beats : req;
  endfunction

endpackage

// File: rtl/bus_burst_reader_if.sv
// Bus side of the burst reader: registered word, its source index and the
// valid/ready beat handshake.
interface bus_burst_reader_if
  import bus_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int SEL_WIDTH  = 3
);

  logic [DATA_WIDTH-1:0] bus_out;
  logic                  bus_valid;
  logic [SEL_WIDTH-1:0]  bus_sel;
  logic                  bus_ready;

  modport master (
    output bus_out,
    output bus_valid,
    output bus_sel,
    input  bus_ready
  );

  modport slave (
    input  bus_out,
    input  bus_valid,
    input  bus_sel,
    output bus_ready
  );

endinterface

// File: rtl/bus_burst_reader_word_mux.sv
// Combinational NUM_REGS:1 word selector over the flattened register bank.
module bus_word_mux #(
  parameter int NUM_REGS   = 8,
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_data,
  input  logic [SEL_WIDTH-1:0]           sel,
  output logic [DATA_WIDTH-1:0]          word
);

  logic [DATA_WIDTH-1:0] words [NUM_REGS];

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_unpack
    assign words[gi] = reg_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign word = words[sel];

endmodule

// File: rtl/bus_burst_reader.sv
// Burst read master: walks consecutive registers from a base index, presenting
// one snapshot word per accepted beat, and pulses done after the last beat.
module bus_burst_reader
  import bus_burst_reader_pkg::*;
#(
  parameter int NUM_REGS   = 8,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int SEL_WIDTH  = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_data,
  input  logic                           start,
  input  logic [SEL_WIDTH-1:0]           base_sel,
  input  logic [SEL_WIDTH:0]             count,
  input  logic                           abort,
  bus_burst_reader_if.master             bus,
  output logic                           busy,
  output logic                           done
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] DRIVE = ST_DRIVE;
  localparam logic [1:0] DONE  = ST_DONE;

  logic [1:0]            state;
  logic [SEL_WIDTH-1:0]  sel_reg;
  logic [SEL_WIDTH:0]    remaining_reg;
  logic [DATA_WIDTH-1:0] out_reg;
  logic                  valid_reg;
  logic                  busy_reg;
  logic                  done_reg;

  logic [SEL_WIDTH-1:0]  next_idx;
  logic [SEL_WIDTH-1:0]  mux_sel;
  logic [DATA_WIDTH-1:0] mux_word;
  logic [SEL_WIDTH:0]    beats_req;
  logic                  accept;

  assign next_idx  = SEL_WIDTH'(wrap_inc(32'(sel_reg), NUM_REGS));
  assign beats_req = (SEL_WIDTH+1)'(clamp_beats(32'(count), NUM_REGS));
  assign accept    = valid_reg && bus.bus_ready;

  // In IDLE the mux looks at the requested base; while driving it looks one
  // index ahead so the next word is ready to load on acceptance.
  assign mux_sel = (state == IDLE) ? base_sel : next_idx;

  bus_word_mux #(
    .NUM_REGS  (NUM_REGS),
    .DATA_WIDTH(DATA_WIDTH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_word_mux (
    .reg_data(reg_data),
    .sel     (mux_sel),
    .word    (mux_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      sel_reg       <= '0;
      remaining_reg <= '0;
      out_reg       <= '0;
      valid_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            if (beats_req != '0) begin
              sel_reg       <= base_sel;
              remaining_reg <= beats_req;
              out_reg       <= mux_word;
              valid_reg     <= 1'b1;
              busy_reg      <= 1'b1;
              state         <= DRIVE;
            end else begin
              done_reg <= 1'b1;
              state    <= DONE;
            end
          end
        end

        DRIVE: begin
          // Abort wins over a simultaneous acceptance and suppresses done.
          if (abort) begin
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            state     <= IDLE;
          end else if (accept) begin
            if (remaining_reg > (SEL_WIDTH+1)'(1)) begin
              sel_reg       <= next_idx;
              remaining_reg <= remaining_reg - (SEL_WIDTH+1)'(1);
              out_reg       <= mux_word;
            end else begin
              remaining_reg <= '0;
              valid_reg     <= 1'b0;
              busy_reg      <= 1'b0;
              done_reg      <= 1'b1;
              state         <= DONE;
            end
          end
        end

        DONE: begin
          done_reg <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.bus_out   = out_reg;
  assign bus.bus_valid = valid_reg;
  assign bus.bus_sel   = sel_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;

endmodule

// File: tb/tb_bus_burst_reader.sv
// Self-checking bench for bus_burst_reader: directed scenarios plus randomized
// bursts checked against a per-beat word/index model.
module tb_bus_burst_reader;

  localparam int NUM_REGS   = 8;
  localparam int DATA_WIDTH = 8;
  localparam int SEL_WIDTH  = 3;

  logic                           clk;
  logic                           reset;
  logic [NUM_REGS*DATA_WIDTH-1:0] reg_data;
  logic                           start;
  logic [SEL_WIDTH-1:0]           base_sel;
  logic [SEL_WIDTH:0]             count;
  logic                           abort;
  logic                           busy;
  logic                           done;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  int checks = 0;
  int errors = 0;

  bus_burst_reader_if #(.DATA_WIDTH(DATA_WIDTH), .SEL_WIDTH(SEL_WIDTH)) bif ();

  bus_burst_reader #(
    .NUM_REGS  (NUM_REGS),
    .DATA_WIDTH(DATA_WIDTH),
    .SEL_WIDTH (SEL_WIDTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .reg_data(reg_data),
    .start   (start),
    .base_sel(base_sel),
    .count   (count),
    .abort   (abort),
    .bus     (bif),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    reg_data = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_data[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

  task automatic load_default_regs();
    for (int i = 0; i < NUM_REGS; i++) regs[i] = 8'(8'h10 + i);
  endtask

  // Runs one burst starting at the current negedge. The model: beat k comes from
  // register (base+k) mod NUM_REGS, sampled at the edge where it is loaded.
  task automatic run_burst(input int base, input int cnt, input int stall_n,
                           input bit rand_ready, input bit mutate, input bit poke);
    int eff;
    int k;
    int cyc;
    int exp_sel;
    logic [DATA_WIDTH-1:0] snap;
    eff = (cnt > NUM_REGS) ? NUM_REGS : cnt;
    k = 0;
    cyc = 0;
    start = 1'b1;
    base_sel = SEL_WIDTH'(base);
    count = (SEL_WIDTH+1)'(cnt);
    abort = 1'b0;
    snap = regs[base % NUM_REGS];
    @(negedge clk);
    start = 1'b0;
    if (eff == 0) begin
      checks++;
      if (bif.bus_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL zero_count: valid=%b done=%b busy=%b, required valid=0 done=1 busy=0",
                 bif.bus_valid, done, busy);
      end
    end else begin
      while (k < eff && cyc < 400) begin
        exp_sel = (base + k) % NUM_REGS;
        checks++;
        if (bif.bus_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL beat_flags beat %0d: valid=%b busy=%b done=%b, required 1 1 0",
                   k, bif.bus_valid, busy, done);
        end
        checks++;
        if (bif.bus_out !== snap) begin
          errors++;
          $display("FAIL beat_word beat %0d: got %h, required %h", k, bif.bus_out, snap);
        end
        checks++;
        if (bif.bus_sel !== SEL_WIDTH'(exp_sel)) begin
          errors++;
          $display("FAIL beat_sel beat %0d: got %0d, required %0d", k, bif.bus_sel, exp_sel);
        end
        if (mutate) for (int i = 0; i < NUM_REGS; i++) regs[i] = 8'($urandom);
        if (poke) begin
          start = 1'b1;
          base_sel = SEL_WIDTH'($urandom);
          count = (SEL_WIDTH+1)'($urandom);
        end
        if (cyc < stall_n) bif.bus_ready = 1'b0;
        else if (rand_ready) bif.bus_ready = 1'($urandom);
        else bif.bus_ready = 1'b1;
        if (bif.bus_ready) begin
          k++;
          if (k < eff) snap = regs[(base + k) % NUM_REGS];
        end
        @(negedge clk);
        cyc++;
      end
      start = 1'b0;
      if (k < eff) begin
        checks++;
        errors++;
        $display("FAIL burst_timeout: beats %0d of %0d after %0d cycles", k, eff, cyc);
      end
      checks++;
      if (bif.bus_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL burst_end: valid=%b done=%b busy=%b, required valid=0 done=1 busy=0",
                 bif.bus_valid, done, busy);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || bif.bus_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_width: done=%b valid=%b, required 0 0", done, bif.bus_valid);
    end
    $display("burst base=%0d count=%0d beats=%0d cycles=%0d", base, cnt, k, cyc);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    base_sel = '0;
    count = '0;
    abort = 1'b0;
    bif.bus_ready = 1'b0;
    load_default_regs();
    @(negedge clk);
    checks++;
    if (bif.bus_out !== '0 || bif.bus_valid !== 1'b0 || bif.bus_sel !== '0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out=%h valid=%b sel=%0d busy=%b done=%b, required all 0",
               bif.bus_out, bif.bus_valid, bif.bus_sel, busy, done);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    load_default_regs();
    run_burst(2, 3, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    load_default_regs();
    run_burst(6, 4, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    load_default_regs();
    run_burst(5, 2, 3, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_count_zero();
    run_burst(4, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    load_default_regs();
    start = 1'b1;
    base_sel = 3'd1;
    count = 4'd5;
    bif.bus_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (bif.bus_sel !== 3'd2 || bif.bus_out !== regs[2]) begin
      errors++;
      $display("FAIL abort_beat2: sel=%0d out=%h, required sel=2 out=%h",
               bif.bus_sel, bif.bus_out, regs[2]);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (bif.bus_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_next: valid=%b busy=%b done=%b, required 0 0 0",
               bif.bus_valid, busy, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || bif.bus_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: done=%b valid=%b, required 0 0", done, bif.bus_valid);
    end
    $display("burst base=1 count=5 aborted at beat 2");
    run_burst(0, 3, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    load_default_regs();
    start = 1'b1;
    base_sel = 3'd3;
    count = 4'd8;
    bif.bus_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bif.bus_out !== '0 || bif.bus_valid !== 1'b0 || bif.bus_sel !== '0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: out=%h valid=%b sel=%0d busy=%b done=%b, required all 0",
               bif.bus_out, bif.bus_valid, bif.bus_sel, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bif.bus_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: valid=%b busy=%b done=%b, required 0 0 0",
               bif.bus_valid, busy, done);
    end
    $display("burst base=3 count=8 discarded by reset");
  endtask

  task automatic test_start_ignored();
    load_default_regs();
    run_burst(3, 6, 0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_clamp();
    load_default_regs();
    run_burst(5, 9, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    load_default_regs();
    run_burst(1, 2, 0, 1'b0, 1'b0, 1'b0);
    run_burst(7, 3, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] = 8'($urandom);
      run_burst($urandom_range(0, NUM_REGS - 1), $urandom_range(0, 15),
                $urandom_range(0, 2), 1'b1, 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_count_zero();
    test_abort();
    test_async_reset();
    test_start_ignored();
    test_clamp();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
